// File: rtl/fetch_packet_unpacker.sv
// Read-side unpacker: pops fetch packets from a one-entry buffer and streams instructions to decode.
// Define FETCH_UNPACK_PERF_EN to add packet-pop and redirect-drop performance counters.
module fetch_packet_unpacker #(
    parameter int unsigned        DataWidth  = 64,
    parameter int unsigned        InstrWidth = 32,
    parameter int unsigned        PcWidth    = 64,
    parameter logic [PcWidth-1:0] ResetPc    = PcWidth'(64'h8000_0000)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DataWidth-1:0]  buf_rdata_i,
    input  logic                  buf_rempty_i,
    output logic                  buf_rinc_o,
    input  logic                  jump_i,
    input  logic [PcWidth-1:0]    jump_pc_i,
    output logic [InstrWidth-1:0] instr_o,
    output logic [PcWidth-1:0]    instr_pc_o,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i
`ifdef FETCH_UNPACK_PERF_EN
    ,
    output logic [31:0]           perf_pkt_cnt_o,
    output logic [15:0]           perf_drop_cnt_o
`endif
);

    localparam int unsigned Lanes  = DataWidth / InstrWidth;
    localparam int unsigned LaneW  = (Lanes > 1) ? $clog2(Lanes) : 1;
    localparam int unsigned PcStep = InstrWidth / 8;

    logic                  pending_q, pending_d;
    logic                  pkt_valid_q, pkt_valid_d;
    logic [DataWidth-1:0]  pkt_q, pkt_d;
    logic [LaneW-1:0]      lane_q, lane_d;
    logic [PcWidth-1:0]    pc_q, pc_d;

    logic [DataWidth-1:0]  source_s;
    logic [InstrWidth-1:0] instr_s;
    logic [LaneW-1:0]      jump_lane_s;
    logic                  held_s;
    logic                  last_lane_s;
    logic                  fire_s;
    logic                  unused_jump_lsb_s;

    // A packet read last cycle is consumed straight off the bus so streaming has no bubble.
    always_comb begin
        source_s = pending_q ? buf_rdata_i : pkt_q;
        instr_s  = {InstrWidth{1'b0}};
        for (int i = 0; i < Lanes; i++) begin
            if (lane_q == LaneW'(i)) begin
                instr_s = source_s[i*InstrWidth +: InstrWidth];
            end else begin
                instr_s = instr_s;
            end
        end
    end

    assign held_s            = pending_q | pkt_valid_q;
    assign last_lane_s       = (lane_q == LaneW'(Lanes - 1));
    assign instr_valid_o     = held_s & ~jump_i;
    assign fire_s            = instr_valid_o & instr_ready_i;
    assign instr_o           = instr_s;
    assign instr_pc_o        = pc_q;
    assign jump_lane_s       = (Lanes > 1) ? jump_pc_i[2 +: LaneW] : {LaneW{1'b0}};
    assign unused_jump_lsb_s = ^jump_pc_i[1:0];

    // Reset gating keeps the pop request quiet while the block is held in reset.
    assign buf_rinc_o = rst_ni & ~buf_rempty_i & ~jump_i & (~held_s | (last_lane_s & fire_s));

    // Next-state logic; a redirect overrides every other event in the cycle.
    always_comb begin
        pending_d   = pending_q;
        pkt_valid_d = pkt_valid_q;
        pkt_d       = pkt_q;
        lane_d      = lane_q;
        pc_d        = pc_q;
        if (jump_i) begin
            pending_d   = 1'b0;
            pkt_valid_d = 1'b0;
            pc_d        = {jump_pc_i[PcWidth-1:2], 2'b00};
            lane_d      = jump_lane_s;
        end else begin
            pending_d = buf_rinc_o;
            if (fire_s) begin
                pc_d   = pc_q + PcWidth'(PcStep);
                lane_d = last_lane_s ? {LaneW{1'b0}} : lane_q + LaneW'(1);
            end else begin
                pc_d   = pc_q;
                lane_d = lane_q;
            end
            if (pending_q && !(fire_s && last_lane_s)) begin
                pkt_d       = buf_rdata_i;
                pkt_valid_d = 1'b1;
            end else if (fire_s && last_lane_s) begin
                pkt_valid_d = 1'b0;
            end else begin
                pkt_valid_d = pkt_valid_q;
            end
        end
    end

    // Unpacker state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q   <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_q       <= {DataWidth{1'b0}};
            lane_q      <= {LaneW{1'b0}};
            pc_q        <= ResetPc;
        end else begin
            pending_q   <= pending_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_q       <= pkt_d;
            lane_q      <= lane_d;
            pc_q        <= pc_d;
        end
    end

`ifdef FETCH_UNPACK_PERF_EN
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Pop count wraps; drop count saturates and only counts redirects that discard something.
    always_comb begin
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (buf_rinc_o) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end else begin
            pkt_cnt_d = pkt_cnt_q;
        end
        if (jump_i && held_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_cnt_q  <= 32'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign perf_pkt_cnt_o  = pkt_cnt_q;
    assign perf_drop_cnt_o = drop_cnt_q;
`endif

endmodule
